// File: rtl/mem_pkg.sv
// Shared constants for the data-memory path: access sizes, rw encoding,
// controller state encoding and the alignment rule.
package mem_pkg;

    localparam logic [1:0] BYTE       = 2'b00;
    localparam logic [1:0] HALFWORD   = 2'b01;
    localparam logic [1:0] WORD       = 2'b10;
    localparam logic [1:0] DOUBLEWORD = 2'b11;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [2:0] addr
    );
        logic ok;
        ok = 1'b0;
        unique case (size)
            BYTE:     ok = 1'b1;
            HALFWORD: ok = ~addr[0];
            WORD:     ok = (addr[1:0] == 2'b00);
            default:  ok = (addr == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response bundle and RAM-side bus of the memory access
// controller; the controller is the slave of the first, master of the second.
interface mem_req_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_type;
    logic              req_signed;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_rw, req_addr, req_type, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_type, req_signed, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface ram_bus_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_mv;
    logic              ram_moc;
    logic              ram_enable;
    logic [1:0]        ram_type;

    modport master (
        output ram_din, ram_rw, ram_addr, ram_mv, ram_enable, ram_type,
        input  ram_dout, ram_moc
    );

    modport slave (
        input  ram_din, ram_rw, ram_addr, ram_mv, ram_enable, ram_type,
        output ram_dout, ram_moc
    );
endinterface

// File: rtl/mem_extend.sv
// Size/sign extension of load data and width masking of store data.
// Purely combinational; shared with the cache fill path.
module mem_extend
    import mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [DATA_W-1:0] load_raw,
    input  logic [DATA_W-1:0] store_raw,
    output logic [DATA_W-1:0] load_ext,
    output logic [DATA_W-1:0] store_mask
);

    always_comb begin
        load_ext   = '0;
        store_mask = '0;
        unique case (size)
            BYTE: begin
                load_ext   = {{(DATA_W-8){sign & load_raw[7]}}, load_raw[7:0]};
                store_mask = {{(DATA_W-8){1'b0}}, store_raw[7:0]};
            end
            HALFWORD: begin
                load_ext   = {{(DATA_W-16){sign & load_raw[15]}}, load_raw[15:0]};
                store_mask = {{(DATA_W-16){1'b0}}, store_raw[15:0]};
            end
            WORD: begin
                load_ext   = {{(DATA_W-32){sign & load_raw[31]}}, load_raw[31:0]};
                store_mask = {{(DATA_W-32){1'b0}}, store_raw[31:0]};
            end
            default: begin
                load_ext   = load_raw;
                store_mask = store_raw;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of ram256x8: one request at a time.
// MEM_ACCESS_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT_CYCLES cycles.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input logic     clk,
    input logic     reset,
    mem_req_if.slave cpu,
    ram_bus_if.master ram
);

    state_t state, next;

    logic              rw_q;
    logic              sgn_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        type_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] store_mask;
    logic              aligned;
    logic              timeout;

    assign aligned = is_aligned(cpu.req_type, cpu.req_addr[2:0]);

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Held at zero outside ACCESS, so it is already clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state != ACCESS)
            cnt <= '0;
        else if (!ram.ram_moc)
            cnt <= cnt + CNT_W'(1);
    end

    assign timeout = (state == ACCESS) && !ram.ram_moc
                  && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next           = state;
        cpu.req_ready  = 1'b0;
        cpu.resp_valid = 1'b0;
        ram.ram_mv     = 1'b0;
        ram.ram_enable = 1'b0;
        unique case (state)
            IDLE: begin
                cpu.req_ready = 1'b1;
                if (cpu.req_valid)
                    next = aligned ? ACCESS : RESP;
            end
            ACCESS: begin
                ram.ram_mv     = 1'b1;
                ram.ram_enable = 1'b1;
                if (ram.ram_moc || timeout)
                    next = RESP;
            end
            RESP: begin
                cpu.resp_valid = 1'b1;
                next           = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu.req_valid) begin
                        rw_q    <= cpu.req_rw;
                        sgn_q   <= cpu.req_signed;
                        addr_q  <= cpu.req_addr;
                        type_q  <= cpu.req_type;
                        wdata_q <= cpu.req_wdata;
                        err_q   <= ~aligned;
                    end
                end
                ACCESS: begin
                    if (ram.ram_moc)
                        dout_q <= ram.ram_dout;
                    else if (timeout)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    mem_extend #(.DATA_W(DATA_W)) u_extend (
        .size       (type_q),
        .sign       (sgn_q),
        .load_raw   (dout_q),
        .store_raw  (wdata_q),
        .load_ext   (load_ext),
        .store_mask (store_mask)
    );

    assign ram.ram_din  = store_mask;
    assign ram.ram_rw   = rw_q;
    assign ram.ram_addr = addr_q;
    assign ram.ram_type = type_q;

    assign cpu.resp_err   = (state == RESP) && err_q;
    // Stores and errored loads return zero data.
    assign cpu.resp_rdata = ((state == RESP) && (rw_q == READ) && !err_q)
                          ? load_ext : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: behavioural RAM responder plus a
// byte-array reference model of the memory contents and load semantics.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_req_if cpu ();
    ram_bus_if ram ();

    mem_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu),
        .ram   (ram)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  ram_arr [256];
    int          moc_delay = 0;
    int          wait_cnt  = 0;
    bit          moc_hold  = 0;
    logic [63:0] last_rd;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM responder: random moc/dout noise outside ACCESS, moc after
    // moc_delay extra cycles inside it, little-endian byte storage.
    initial begin
        ram.ram_moc  = 1'b0;
        ram.ram_dout = '0;
        forever begin
            @(negedge clk);
            ram.ram_dout = {$urandom, $urandom};
            if (ram.ram_mv && !moc_hold && wait_cnt == moc_delay) begin
                ram.ram_moc = 1'b1;
                for (int i = 0; i < (1 << ram.ram_type); i++) begin
                    if (ram.ram_rw == WRITE)
                        ram_arr[8'(ram.ram_addr + i)] = ram.ram_din[8*i +: 8];
                    else
                        ram.ram_dout[8*i +: 8] = ram_arr[8'(ram.ram_addr + i)];
                end
                wait_cnt++;
            end else if (ram.ram_mv) begin
                ram.ram_moc = 1'b0;
                wait_cnt++;
            end else begin
                ram.ram_moc = 1'($urandom);
                wait_cnt = 0;
            end
        end
    end

    function automatic logic [63:0] ref_load(logic [7:0] a, logic [1:0] t,
                                             logic s);
        int n = 1 << t;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            v = v | (64'(ref_mem[8'(a + i)]) << (8 * i));
        if (s && n < 8 && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic run_txn(logic rw, logic [7:0] a, logic [1:0] t, logic s,
                           logic [63:0] wd, int d);
        int n = 1 << t;
        bit ok = ((a % n) == 0);
        logic [63:0] exp_rd = '0;
        logic [63:0] exp_din;
        logic [63:0] din0 = '0;
        logic [10:0] ctl0 = '0;
        logic [63:0] rd = '0;
        logic er = 1'b0;
        int lat = 0;
        int mvc = 0;
        bit stable = 1;
        bit got = 0;

        exp_din = (n == 8) ? wd : (wd & ((64'd1 << (8 * n)) - 64'd1));
        if (ok && rw == READ)
            exp_rd = ref_load(a, t, s);
        if (ok && rw == WRITE)
            for (int i = 0; i < n; i++)
                ref_mem[8'(a + i)] = wd[8*i +: 8];

        @(negedge clk);
        check("resp_pulse", cpu.resp_valid, 1'b0);
        check("ready", cpu.req_ready, 1'b1);
        moc_delay      = d;
        cpu.req_valid  = 1'b1;
        cpu.req_rw     = rw;
        cpu.req_addr   = a;
        cpu.req_type   = t;
        cpu.req_signed = s;
        cpu.req_wdata  = wd;
        @(negedge clk);
        cpu.req_valid  = 1'b0;
        cpu.req_addr   = 8'($urandom);
        cpu.req_type   = 2'($urandom);
        cpu.req_signed = 1'($urandom);
        cpu.req_wdata  = {$urandom, $urandom};
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c > 1)
                @(negedge clk);
            if (ram.ram_mv) begin
                if (mvc == 0) begin
                    din0 = ram.ram_din;
                    ctl0 = {ram.ram_rw, ram.ram_addr, ram.ram_type};
                end else if (din0 !== ram.ram_din ||
                             ctl0 !== {ram.ram_rw, ram.ram_addr, ram.ram_type}) begin
                    stable = 0;
                end
                mvc++;
            end
            if (cpu.resp_valid) begin
                got = 1;
                lat = c;
                rd  = cpu.resp_rdata;
                er  = cpu.resp_err;
            end
        end
        last_rd = rd;
        check("resp_seen", got, 1'b1);
        check("latency", lat, ok ? d + 2 : 1);
        check("err", er, !ok);
        check("rdata", rd, exp_rd);
        check("mv_cycles", mvc, ok ? d + 1 : 0);
        if (ok) begin
            check("din", din0, exp_din);
            check("ctl", ctl0, {rw, a, t});
            check("stable", stable, 1'b1);
        end
    endtask

    task automatic start_stuck();
        @(negedge clk);
        moc_hold       = 1;
        cpu.req_valid  = 1'b1;
        cpu.req_rw     = READ;
        cpu.req_addr   = 8'h10;
        cpu.req_type   = WORD;
        cpu.req_signed = 1'b0;
        cpu.req_wdata  = '0;
        @(negedge clk);
        cpu.req_valid  = 1'b0;
    endtask

    initial begin
        bit got;
        int lat;
        int seen;
        logic er;
        logic [63:0] rd;

        cpu.req_valid  = 1'b0;
        cpu.req_rw     = 1'b0;
        cpu.req_addr   = '0;
        cpu.req_type   = '0;
        cpu.req_signed = 1'b0;
        cpu.req_wdata  = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            ram_arr[i] = ref_mem[i];
        end

        #1 reset = 1'b1;
        #2;
        check("rst_ready", cpu.req_ready, 1'b1);
        check("rst_mv", ram.ram_mv, 1'b0);
        check("rst_en", ram.ram_enable, 1'b0);
        check("rst_resp", cpu.resp_valid, 1'b0);
        check("rst_rdata", cpu.resp_rdata, 64'd0);
        check("rst_din", ram.ram_din, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_txn(WRITE, 8'h02, BYTE, 1'b0, 64'h9a, 1);
        run_txn(READ, 8'h02, BYTE, 1'b1, 64'd0, 0);
        check("tp_byte_signed", last_rd, 64'hffffffffffffff9a);
        run_txn(WRITE, 8'h04, HALFWORD, 1'b0, 64'h1234_5678_9abc_bebe, 2);
        run_txn(READ, 8'h04, HALFWORD, 1'b0, 64'd0, 1);
        check("tp_half_unsigned", last_rd, 64'h000000000000bebe);
        run_txn(READ, 8'h06, WORD, 1'b1, 64'd0, 0);
        run_txn(WRITE, 8'h08, DOUBLEWORD, 1'b1, 64'hcafefeafbebeabee, 3);
        run_txn(READ, 8'h08, DOUBLEWORD, 1'b1, 64'd0, 2);
        check("tp_dword", last_rd, 64'hcafefeafbebeabee);

        for (int k = 0; k < 200; k++) begin
            logic [1:0] t = 2'($urandom);
            logic [7:0] a = 8'($urandom);
            if ($urandom_range(3, 0) != 0)
                a = a & ~8'((1 << t) - 1);
            run_txn(1'($urandom), a, t, 1'($urandom), {$urandom, $urandom},
                    $urandom_range(3, 0));
        end

        // Stuck access: moc never arrives.
        start_stuck();
        got = 0; lat = 0; er = 1'b0; rd = '0;
        for (int c = 1; c <= 100 && !got; c++) begin
            if (c > 1)
                @(negedge clk);
            if (cpu.resp_valid) begin
                got = 1;
                lat = c;
                er  = cpu.resp_err;
                rd  = cpu.resp_rdata;
            end
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        check("to_seen", got, 1'b1);
        check("to_latency", lat, 17);
        check("to_err", er, 1'b1);
        check("to_rdata", rd, 64'd0);
        start_stuck();
        repeat (3) @(negedge clk);
`else
        check("no_resp_stuck", got, 1'b0);
`endif

        // Async reset while ACCESS is in flight.
        check("mv_before_rst", ram.ram_mv, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_mv", ram.ram_mv, 1'b0);
        check("rst_mid_en", ram.ram_enable, 1'b0);
        check("rst_mid_ready", cpu.req_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        moc_hold = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cpu.resp_valid)
                seen++;
        end
        check("no_resp_after_rst", seen, 0);

        run_txn(WRITE, 8'h20, WORD, 1'b0, 64'hffff_ffff_8765_4321, 0);
        run_txn(READ, 8'h20, WORD, 1'b1, 64'd0, 1);
        check("post_rst_word", last_rd, 64'hffffffff87654321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
